photonic_tx_serialiser: RTL and testbench
=========================================

# photonic_tx_serialiser

Buffered, parametrised successor to the single-cycle packet transmitter in the photonic transceiver. It accepts {dest_id, data, src_id} packets over a valid/ready handshake and queues them in a DEPTH-entry FIFO. Each packet is serialised MSB-first onto LANES optical lanes as framed beats, with start- and end-of-frame markers. It sits between a core's network interface and the waveguide modulator driver; link_ready models the waveguide arbitration grant.

## Interface
- DEST_W, 1, destination-ID width (≥1)
- DATA_W, 1, payload width (≥1)
- SRC_W, 1, source-ID width (≥1)
- LANES, 1, optical lanes driven per beat (≥1)
- DEPTH, 4, FIFO entries (power of 2, ≥2)
- Derived: FRAME_W = DEST_W+DATA_W+SRC_W (+1 with parity); BEATS = ceil(FRAME_W/LANES)
- Clocking and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- dest_id  in  DEST_W  packet destination
- data  in  DATA_W  packet payload
- src_id  in  SRC_W  packet source
- in_valid  in  1  packet offered
- in_ready  out  1  FIFO not full
- link_ready  in  1  waveguide granted; beat advances when high
- tx_out  out  LANES  current beat, lane LANES-1 = earliest frame bit
- tx_valid  out  1  beat on tx_out is valid
- tx_sof  out  1  first beat of frame
- tx_eof  out  1  last beat of frame
- fifo_count  out  $clog2(DEPTH+1)  queued packets (excludes packet in flight)

## Operation
- Frame bits, MSB first: dest_id, data, src_id, [parity]. The final beat is zero-padded in its low lanes.
- Push: in_valid && in_ready at an edge writes one FIFO entry. in_ready = (fifo_count != DEPTH), registered-state only. There is no pass-through when full, even if a pop occurs the same cycle.
- FSM states: IDLE and SEND. A beat counter runs 0..BEATS-1.
  - IDLE: if FIFO is non-empty, pop, load the shift register, set counter = 0, go to SEND.
  - SEND: tx_valid = 1. On an edge with link_ready = 1, shift by LANES and increment the counter.
  - On the last beat with link_ready = 1: if FIFO is non-empty, pop and load the next frame back-to-back with no bubble; otherwise go to IDLE.
  - link_ready = 0 holds tx_out, tx_sof and tx_eof unchanged.
- tx_sof = SEND && counter == 0. tx_eof = SEND && counter == BEATS-1. If BEATS == 1, both are high on the same beat.
- Simultaneous push and pop updates fifo_count by net 0. Read and write pointers wrap modulo DEPTH.
- Reset values: tx_out = 0, tx_valid = 0, tx_sof = 0, tx_eof = 0, fifo_count = 0, in_ready = 1, state = IDLE.
- Asserting rst mid-frame drops all outputs immediately and discards the in-flight frame and all queued packets.

## Timing
- tx_out, tx_valid, tx_sof and tx_eof are driven from registers only; there is no combinational path from inputs to outputs.
- A packet pushed into an empty, idle block at edge N is popped at edge N+1. Its first beat is visible from N+1 to N+2.
- With link_ready held high, a frame occupies exactly BEATS cycles. Consecutive frames are contiguous.
- in_ready falls in the cycle after the push that fills the FIFO.

## Configuration
- TX_PARITY_EN defined: an even-parity bit over dest_id, data and src_id is appended as the final frame bit, and FRAME_W is incremented by 1.
- TX_PARITY_EN undefined: no parity bit; FRAME_W = DEST_W+DATA_W+SRC_W.

## Test plan
- Defaults, no macro, dest=1, data=0, src=1 pushed, link_ready = 1 → tx_out = 1, 0, 1 over 3 cycles; sof on beat 0, eof on beat 2.
- DEST_W=2, DATA_W=8, SRC_W=2, LANES=4, no macro, push {2'b10, 8'hA5, 2'b11} → beats 4'hA, 4'h9, 4'h7.
- Same parameters with TX_PARITY_EN → beats 4'hA, 4'h9, 4'h7, 4'h8 (parity 1, padded); eof on beat 3.
- DEPTH=4, link_ready = 0, push 6 packets with in_valid held → 4 accepted plus 1 popped into SEND. in_ready = 0 and fifo_count = 4. Release link_ready → 5 frames output back-to-back in order with no bubbles.
- link_ready toggling every cycle mid-frame → each beat held while low; no beat lost or duplicated.
- rst asserted on beat 1 of a frame with 2 queued packets → outputs 0 immediately, fifo_count = 0, in_ready = 1; the next push transmits normally.

Source files
------------

// File: rtl/photonic_tx_serialiser.sv
`default_nettype none
// ============================================================================
// Module      : photonic_tx_serialiser
// Description : Buffered packet serialiser. Queues {dest_id, data, src_id}
//               packets in a DEPTH-entry FIFO and emits each one MSB-first
//               across LANES optical lanes as framed beats (sof/eof marked).
//               Optional macro TX_PARITY_EN appends an even-parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
module photonic_tx_serialiser #(
    parameter int DEST_W = 1,
    parameter int DATA_W = 1,
    parameter int SRC_W  = 1,
    parameter int LANES  = 1,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DEST_W-1:0]          dest_id,
    input  logic [DATA_W-1:0]          data,
    input  logic [SRC_W-1:0]           src_id,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       link_ready,
    output logic [LANES-1:0]           tx_out,
    output logic                       tx_valid,
    output logic                       tx_sof,
    output logic                       tx_eof,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

`ifdef TX_PARITY_EN
    localparam int c_PAR_W = 1;
`else
    localparam int c_PAR_W = 0;
`endif
    localparam int c_PAY_W   = DEST_W + DATA_W + SRC_W;
    localparam int c_FRAME_W = c_PAY_W + c_PAR_W;
    localparam int c_BEATS   = (c_FRAME_W + LANES - 1) / LANES;
    localparam int c_SHIFT_W = c_BEATS * LANES;
    localparam int c_CNT_W   = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_FC_W    = $clog2(DEPTH + 1);

    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_BEATS - 1);
    localparam logic [c_FC_W-1:0]  c_FULL = c_FC_W'(DEPTH);

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_SEND = 1'b1;

    logic [c_FRAME_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_FC_W-1:0]    r_count;
    logic [0:0]           r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_SHIFT_W-1:0] r_shift;
    logic                 r_valid;
    logic                 r_sof;
    logic                 r_eof;

    logic [c_PAY_W-1:0]   w_payload;
    logic [c_FRAME_W-1:0] w_frame;
    logic [c_SHIFT_W-1:0] w_load;
    logic                 w_empty;
    logic                 w_last;
    logic                 w_push;
    logic                 w_pop;

    assign w_payload = {dest_id, data, src_id};
`ifdef TX_PARITY_EN
    assign w_frame = {w_payload, ^w_payload};
`else
    assign w_frame = w_payload;
`endif

    assign w_empty = (r_count == '0);
    assign w_last  = (r_cnt == c_LAST);
    assign in_ready = (r_count != c_FULL);
    assign w_push  = in_valid && in_ready;
    // A pop either starts from idle or chains onto the last beat of the
    // current frame so consecutive frames leave no bubble.
    assign w_pop   = !w_empty &&
                     ((r_state == c_S_IDLE) ||
                      (link_ready && w_last));

    // Frame is left-justified so the final beat is zero-padded in low lanes.
    always_comb begin
        w_load = '0;
        w_load[c_SHIFT_W-1 -: c_FRAME_W] = r_mem[r_rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_frame;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_FC_W'(1);
                2'b01:   r_count <= r_count - c_FC_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_sof   <= 1'b0;
            r_eof   <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_pop) begin
                        r_state <= c_S_SEND;
                        r_shift <= w_load;
                        r_cnt   <= '0;
                        r_valid <= 1'b1;
                        r_sof   <= 1'b1;
                        r_eof   <= (c_BEATS == 1);
                    end
                end
                c_S_SEND: begin
                    if (link_ready) begin
                        if (w_last) begin
                            if (w_pop) begin
                                r_shift <= w_load;
                                r_cnt   <= '0;
                                r_sof   <= 1'b1;
                                r_eof   <= (c_BEATS == 1);
                            end else begin
                                r_state <= c_S_IDLE;
                                r_shift <= '0;
                                r_cnt   <= '0;
                                r_valid <= 1'b0;
                                r_sof   <= 1'b0;
                                r_eof   <= 1'b0;
                            end
                        end else begin
                            r_shift <= r_shift << LANES;
                            r_cnt   <= r_cnt + c_CNT_W'(1);
                            r_sof   <= 1'b0;
                            r_eof   <= ((r_cnt + c_CNT_W'(1)) == c_LAST);
                        end
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    assign tx_out     = r_shift[c_SHIFT_W-1 -: LANES];
    assign tx_valid   = r_valid;
    assign tx_sof     = r_sof;
    assign tx_eof     = r_eof;
    assign fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_photonic_tx_serialiser.sv
`default_nettype none
// ============================================================================
// Module      : tb_photonic_tx_serialiser
// Description : Directed bench for photonic_tx_serialiser: a default-size
//               instance (A) and a 2/8/2-bit, 4-lane instance (B).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_photonic_tx_serialiser;

`ifdef TX_PARITY_EN
    localparam int c_NB_A = 4;
    localparam int c_NB_B = 4;
`else
    localparam int c_NB_A = 3;
    localparam int c_NB_B = 3;
`endif

    typedef struct {
        logic [1:0]  dest;
        logic [7:0]  data;
        logic [1:0]  src;
        logic [11:0] nibs;  // hand-computed beats without parity
        logic        par;   // hand-computed even parity
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       dest_a, data_a, src_a, in_valid_a, in_ready_a, link_ready_a;
    logic [0:0] tx_out_a;
    logic       tx_valid_a, tx_sof_a, tx_eof_a;
    logic [2:0] fifo_count_a;

    logic [1:0] dest_b;
    logic [7:0] data_b;
    logic [1:0] src_b;
    logic       in_valid_b, in_ready_b, link_ready_b;
    logic [3:0] tx_out_b;
    logic       tx_valid_b, tx_sof_b, tx_eof_b;
    logic [2:0] fifo_count_b;

    int checks = 0;
    int errors = 0;
    vec_t vecs[5];

    photonic_tx_serialiser u_dut_a (
        .clk(clk), .rst(rst), .dest_id(dest_a), .data(data_a), .src_id(src_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .link_ready(link_ready_a),
        .tx_out(tx_out_a), .tx_valid(tx_valid_a), .tx_sof(tx_sof_a),
        .tx_eof(tx_eof_a), .fifo_count(fifo_count_a)
    );

    photonic_tx_serialiser #(
        .DEST_W(2), .DATA_W(8), .SRC_W(2), .LANES(4), .DEPTH(4)
    ) u_dut_b (
        .clk(clk), .rst(rst), .dest_id(dest_b), .data(data_b), .src_id(src_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .link_ready(link_ready_b),
        .tx_out(tx_out_b), .tx_valid(tx_valid_b), .tx_sof(tx_sof_b),
        .tx_eof(tx_eof_b), .fifo_count(fifo_count_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Instance A packet p carries dest=p[2], data=p[1], src=p[0].
    function automatic logic exp_a(input int p, input int b);
        logic [2:0] f;
        f = 3'(p);
        if (b < 3) return f[2-b];
        return ^f;
    endfunction

    function automatic logic [3:0] exp_b(input vec_t v, input int b);
        logic [11:0] n;
        n = v.nibs;
        if (b < 3) return n[11-4*b -: 4];
        return {v.par, 3'b000};
    endfunction

    task automatic drive_b(input vec_t v);
        dest_b = v.dest; data_b = v.data; src_b = v.src;
    endtask

    task automatic run_vec_b(input vec_t v);
        @(negedge clk);
        drive_b(v);
        in_valid_b = 1'b1;
        @(negedge clk);
        in_valid_b = 1'b0;
        chk("b_lat_valid", 32'(tx_valid_b), 0);
        chk("b_lat_count", 32'(fifo_count_b), 1);
        for (int b = 0; b < c_NB_B; b++) begin
            @(negedge clk);
            chk("b_valid", 32'(tx_valid_b), 1);
            chk("b_beat", 32'(tx_out_b), 32'(exp_b(v, b)));
            chk("b_sof", 32'(tx_sof_b), 32'(b == 0));
            chk("b_eof", 32'(tx_eof_b), 32'(b == c_NB_B - 1));
        end
        @(negedge clk);
        chk("b_end_valid", 32'(tx_valid_b), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int steps;

        vecs[0] = '{dest: 2'b10, data: 8'hA5, src: 2'b11, nibs: 12'hA97, par: 1'b1};
        vecs[1] = '{dest: 2'b01, data: 8'h3C, src: 2'b00, nibs: 12'h4F0, par: 1'b1};
        vecs[2] = '{dest: 2'b11, data: 8'hFF, src: 2'b10, nibs: 12'hFFE, par: 1'b1};
        vecs[3] = '{dest: 2'b00, data: 8'h00, src: 2'b00, nibs: 12'h000, par: 1'b0};
        vecs[4] = '{dest: 2'b10, data: 8'h81, src: 2'b01, nibs: 12'hA05, par: 1'b0};

        rst = 1'b1;
        dest_a = 0; data_a = 0; src_a = 0; in_valid_a = 0; link_ready_a = 1;
        dest_b = 0; data_b = 0; src_b = 0; in_valid_b = 0; link_ready_b = 1;
        repeat (2) @(negedge clk);
        chk("rst_out_a", 32'(tx_out_a), 0);
        chk("rst_valid_a", 32'(tx_valid_a), 0);
        chk("rst_sof_eof_a", 32'({tx_sof_a, tx_eof_a}), 0);
        chk("rst_count_a", 32'(fifo_count_a), 0);
        chk("rst_ready_a", 32'(in_ready_a), 1);
        chk("rst_out_b", 32'(tx_out_b), 0);
        chk("rst_valid_b", 32'(tx_valid_b), 0);
        chk("rst_ready_b", 32'(in_ready_b), 1);
        rst = 1'b0;

        // Default instance: dest=1 data=0 src=1 -> 1,0,1 (+parity 0)
        @(negedge clk);
        dest_a = 1; data_a = 0; src_a = 1; in_valid_a = 1;
        @(negedge clk);
        in_valid_a = 0;
        chk("a_lat_valid", 32'(tx_valid_a), 0);
        for (int b = 0; b < c_NB_A; b++) begin
            @(negedge clk);
            chk("a_valid", 32'(tx_valid_a), 1);
            chk("a_beat", 32'(tx_out_a), 32'(exp_a(5, b)));
            chk("a_sof", 32'(tx_sof_a), 32'(b == 0));
            chk("a_eof", 32'(tx_eof_a), 32'(b == c_NB_A - 1));
        end
        @(negedge clk);
        chk("a_end_valid", 32'(tx_valid_a), 0);

        for (int i = 0; i < 5; i++) run_vec_b(vecs[i]);

        // Fill with link stalled: 5 accepted (1 in flight + 4 queued), 6th refused
        link_ready_a = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("fill_ready", 32'(in_ready_a), 32'(k < 5));
            {dest_a, data_a, src_a} = 3'(k);
            in_valid_a = 1;
        end
        @(negedge clk);
        in_valid_a = 0;
        chk("fill_count", 32'(fifo_count_a), 4);
        chk("fill_ready_low", 32'(in_ready_a), 0);
        repeat (2) begin
            @(negedge clk);
            chk("stall_sof", 32'(tx_sof_a), 1);
            chk("stall_beat", 32'(tx_out_a), 32'(exp_a(0, 0)));
        end
        for (int j = 0; j < 5 * c_NB_A; j++) begin
            if (j > 0) @(negedge clk);
            chk("drain_valid", 32'(tx_valid_a), 1);
            chk("drain_beat", 32'(tx_out_a), 32'(exp_a(j / c_NB_A, j % c_NB_A)));
            chk("drain_sof", 32'(tx_sof_a), 32'((j % c_NB_A) == 0));
            chk("drain_eof", 32'(tx_eof_a), 32'((j % c_NB_A) == c_NB_A - 1));
            if (j == 0) link_ready_a = 1;
        end
        @(negedge clk);
        chk("drain_end_valid", 32'(tx_valid_a), 0);
        chk("drain_end_count", 32'(fifo_count_a), 0);

        // link_ready toggling each cycle: each beat held while low
        link_ready_b = 0;
        @(negedge clk);
        drive_b(vecs[0]);
        in_valid_b = 1;
        @(negedge clk);
        in_valid_b = 0;
        idx = 0;
        steps = 0;
        while (idx < c_NB_B && steps < 30) begin
            @(negedge clk);
            steps++;
            chk("tog_valid", 32'(tx_valid_b), 1);
            chk("tog_beat", 32'(tx_out_b), 32'(exp_b(vecs[0], idx)));
            chk("tog_sof", 32'(tx_sof_b), 32'(idx == 0));
            chk("tog_eof", 32'(tx_eof_b), 32'(idx == c_NB_B - 1));
            link_ready_b = ~link_ready_b;
            if (link_ready_b) idx++;
        end
        chk("tog_bound", 32'(steps < 30), 1);
        @(negedge clk);
        chk("tog_end_valid", 32'(tx_valid_b), 0);

        // Reset on beat 1 with two packets queued
        link_ready_b = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive_b(vecs[k]);
            in_valid_b = 1;
        end
        @(negedge clk);
        in_valid_b = 0;
        chk("rq_count", 32'(fifo_count_b), 2);
        link_ready_b = 1;
        @(negedge clk);
        chk("rq_beat1", 32'(tx_out_b), 32'(exp_b(vecs[0], 1)));
        chk("rq_sof", 32'(tx_sof_b), 0);
        #2 rst = 1'b1;
        #1;
        chk("rq_rst_out", 32'(tx_out_b), 0);
        chk("rq_rst_valid", 32'(tx_valid_b), 0);
        chk("rq_rst_count", 32'(fifo_count_b), 0);
        chk("rq_rst_ready", 32'(in_ready_b), 1);
        @(negedge clk);
        rst = 1'b0;
        run_vec_b(vecs[4]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
